// File: rtl/mips_ex_pkg.sv
// Shared constants and types for the EX result stage: ALU op codes,
// HI/LO read selects, exception cause codes and the stage state enum.
package mips_ex_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUBU  = 4'b0011;
    localparam logic [3:0] OP_SSUB  = 4'b1011;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_MULT  = 4'b1110;
    localparam logic [3:0] OP_DIV   = 4'b1111;

    localparam logic [1:0] HILO_NONE = 2'b00;
    localparam logic [1:0] HILO_MFHI = 2'b01;
    localparam logic [1:0] HILO_MFLO = 2'b10;

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_OVF  = 2'b01;
    localparam logic [1:0] EXC_DIV0 = 2'b10;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } state_t;

    // Multiply/divide ops occupy the top quarter of the op-code space.
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    function automatic logic is_trap_arith(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUBU) || (op == OP_SSUB);
    endfunction

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair with a shared write enable and the
// MFHI/MFLO read mux (reads return the value held before this cycle's write).
module hilo_regs
    import mips_ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DATA_W-1:0] wr_hi,
    input  logic [DATA_W-1:0] wr_lo,
    input  logic [1:0]        rd_sel,
    input  logic [DATA_W-1:0] rd_default,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (we) begin
            hi <= wr_hi;
            lo <= wr_lo;
        end
    end

    // The reserved select value falls through to the plain ALU result.
    always_comb begin
        rd_data = rd_default;
        case (rd_sel)
            HILO_MFHI: rd_data = hi;
            HILO_MFLO: rd_data = lo;
            default:   rd_data = rd_default;
        endcase
    end

endmodule

// File: rtl/ex_result_stage.sv
// EX/MEM pipeline register behind the ALU: valid/ready handshake, HI/LO
// ownership, and overflow/divide-by-zero trapping with a held exception record.
module ex_result_stage
    import mips_ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out1,
    input  logic [DATA_W-1:0] alu_out2,
    input  logic              alu_o,
    input  logic              alu_z,
    input  logic [3:0]        alu_ctrl,
    input  logic              trap_ovf,
    input  logic [1:0]        hilo_op,
    input  logic [REG_W-1:0]  dest_reg,
    input  logic              reg_write,
    input  logic [DATA_W-1:0] pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [REG_W-1:0]  out_dest,
    output logic              out_reg_write,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              flush,
    output logic              exc_valid,
    output logic [1:0]        exc_cause,
    output logic [DATA_W-1:0] exc_pc,
    input  logic              exc_ack
);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              div0_exc;
    logic              ovf_exc;
    logic              fault_accept;
    logic              good_accept;
    logic              hilo_we;
    logic [DATA_W-1:0] result_mux;

    assign in_ready     = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept       = in_valid && in_ready;
    assign div0_exc     = alu_o && is_div(alu_ctrl);
    assign ovf_exc      = trap_ovf && alu_o && is_trap_arith(alu_ctrl);
    assign fault_accept = accept && (div0_exc || ovf_exc);
    assign good_accept  = accept && !(div0_exc || ovf_exc);
    assign hilo_we      = good_accept && is_muldiv(alu_ctrl);

    hilo_regs #(
        .DATA_W(DATA_W)
    ) u_hilo (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (hilo_we),
        .wr_hi     (alu_out2),
        .wr_lo     (alu_out1),
        .rd_sel    (hilo_op),
        .rd_default(alu_out1),
        .rd_data   (result_mux),
        .hi        (hi),
        .lo        (lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:  if (fault_accept) state_next = ST_EXC;
            ST_EXC:  if (exc_ack)      state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    // A faulting instruction never enters EX/MEM; the held entry drains as usual.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_zero      <= 1'b0;
            out_dest      <= '0;
            out_reg_write <= 1'b0;
        end else if (good_accept) begin
            out_valid     <= 1'b1;
            out_result    <= result_mux;
            out_zero      <= alu_z;
            out_dest      <= dest_reg;
            out_reg_write <= reg_write && !is_muldiv(alu_ctrl);
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush     <= 1'b0;
            exc_valid <= 1'b0;
            exc_cause <= EXC_NONE;
            exc_pc    <= '0;
        end else begin
            flush <= fault_accept;
            if (fault_accept) begin
                exc_valid <= 1'b1;
                exc_cause <= div0_exc ? EXC_DIV0 : EXC_OVF;
                exc_pc    <= pc;
            end else if ((state == ST_EXC) && exc_ack) begin
                exc_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_result_stage.sv
// Self-checking bench for ex_result_stage: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_ex_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out1;
    logic [31:0] alu_out2;
    logic        alu_o;
    logic        alu_z;
    logic [3:0]  alu_ctrl;
    logic        trap_ovf;
    logic [1:0]  hilo_op;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_dest;
    logic        out_reg_write;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        flush;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        exc_ack;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic        m_run;
    logic        m_full;
    logic [31:0] m_result;
    logic        m_zero;
    logic [4:0]  m_dest;
    logic        m_rw;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_flush;
    logic        m_exc;
    logic [1:0]  m_cause;
    logic [31:0] m_pc;

    ex_result_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_out1     (alu_out1),
        .alu_out2     (alu_out2),
        .alu_o        (alu_o),
        .alu_z        (alu_z),
        .alu_ctrl     (alu_ctrl),
        .trap_ovf     (trap_ovf),
        .hilo_op      (hilo_op),
        .dest_reg     (dest_reg),
        .reg_write    (reg_write),
        .pc           (pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_dest     (out_dest),
        .out_reg_write(out_reg_write),
        .hi           (hi),
        .lo           (lo),
        .flush        (flush),
        .exc_valid    (exc_valid),
        .exc_cause    (exc_cause),
        .exc_pc       (exc_pc),
        .exc_ack      (exc_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_run    = 1'b1;
        m_full   = 1'b0;
        m_result = '0;
        m_zero   = 1'b0;
        m_dest   = '0;
        m_rw     = 1'b0;
        m_hi     = '0;
        m_lo     = '0;
        m_flush  = 1'b0;
        m_exc    = 1'b0;
        m_cause  = 2'b00;
        m_pc     = '0;
    endtask

    // One clock edge of the architectural rules, evaluated on pre-edge values.
    task automatic modelEdge();
        int  op;
        bit  ready;
        bit  taken;
        bit  div0;
        bit  ovf;
        op    = int'(alu_ctrl);
        ready = m_run && (!m_full || out_ready);
        taken = in_valid && ready;
        div0  = alu_o && (op == 13 || op == 15);
        ovf   = trap_ovf && alu_o && (op == 2 || op == 3 || op == 11);
        m_flush = taken && (div0 || ovf);
        if (taken && !(div0 || ovf)) begin
            if (hilo_op == 2'd1)      m_result = m_hi;
            else if (hilo_op == 2'd2) m_result = m_lo;
            else                      m_result = alu_out1;
            m_zero = alu_z;
            m_dest = dest_reg;
            m_rw   = reg_write && (op < 12);
            m_full = 1'b1;
            if (op >= 12) begin
                m_hi = alu_out2;
                m_lo = alu_out1;
            end
        end else if (out_ready) begin
            m_full = 1'b0;
        end
        if (taken && (div0 || ovf)) begin
            m_exc   = 1'b1;
            m_cause = div0 ? 2'b10 : 2'b01;
            m_pc    = pc;
            m_run   = 1'b0;
        end else if (!m_run && exc_ack) begin
            m_exc = 1'b0;
            m_run = 1'b1;
        end
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, ".in_ready"}, 32'(in_ready), 32'(m_run && (!m_full || out_ready)));
        checkOutput({where, ".out_valid"}, 32'(out_valid), 32'(m_full));
        checkOutput({where, ".out_result"}, out_result, m_result);
        checkOutput({where, ".out_zero"}, 32'(out_zero), 32'(m_zero));
        checkOutput({where, ".out_dest"}, 32'(out_dest), 32'(m_dest));
        checkOutput({where, ".out_reg_write"}, 32'(out_reg_write), 32'(m_rw));
        checkOutput({where, ".hi"}, hi, m_hi);
        checkOutput({where, ".lo"}, lo, m_lo);
        checkOutput({where, ".flush"}, 32'(flush), 32'(m_flush));
        checkOutput({where, ".exc_valid"}, 32'(exc_valid), 32'(m_exc));
        checkOutput({where, ".exc_cause"}, 32'(exc_cause), 32'(m_cause));
        checkOutput({where, ".exc_pc"}, exc_pc, m_pc);
    endtask

    task automatic step(input string where);
        @(posedge clk);
        modelEdge();
        #1;
        checkAll(where);
    endtask

    task automatic applyStimulus(input string where, input logic v, input logic [3:0] ctrl,
                                 input logic [31:0] o1, input logic [31:0] o2, input logic ao,
                                 input logic trap, input logic [1:0] hop, input logic [31:0] pcv,
                                 input logic ordy, input logic ack);
        in_valid  = v;
        alu_ctrl  = ctrl;
        alu_out1  = o1;
        alu_out2  = o2;
        alu_o     = ao;
        alu_z     = (o1 == 32'd0);
        trap_ovf  = trap;
        hilo_op   = hop;
        pc        = pcv;
        out_ready = ordy;
        exc_ack   = ack;
        dest_reg  = 5'($urandom);
        reg_write = 1'b1;
        step(where);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; alu_out1 = 0; alu_out2 = 0; alu_o = 0; alu_z = 0; alu_ctrl = 0;
        trap_ovf = 0; hilo_op = 0; dest_reg = 0; reg_write = 0; pc = 0; out_ready = 0; exc_ack = 0;
        modelReset();
        #12;
        checkAll("reset");
        checkOutput("reset.in_ready_hi", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain ADD
        applyStimulus("add", 1, 4'b0010, 32'd12, 32'd0, 0, 0, 2'b00, 32'h10, 1, 0);
        checkOutput("add.result12", out_result, 32'd12);
        checkOutput("add.valid", 32'(out_valid), 32'd1);

        // MULTU then MFHI / MFLO
        applyStimulus("multu", 1, 4'b1100, 32'hFFFF_FFFE, 32'h1, 0, 0, 2'b00, 32'h14, 1, 0);
        checkOutput("multu.hi", hi, 32'h1);
        checkOutput("multu.lo", lo, 32'hFFFF_FFFE);
        checkOutput("multu.rw", 32'(out_reg_write), 32'd0);
        applyStimulus("mfhi", 1, 4'b0000, 32'hDEAD, 32'h0, 0, 0, 2'b01, 32'h18, 1, 0);
        checkOutput("mfhi.result", out_result, 32'h1);
        applyStimulus("mflo", 1, 4'b0000, 32'hBEEF, 32'h0, 0, 0, 2'b10, 32'h1C, 1, 0);
        checkOutput("mflo.result", out_result, 32'hFFFF_FFFE);

        // Overflow trap on ADD
        applyStimulus("ovf", 1, 4'b0010, 32'h0, 32'h0, 1, 1, 2'b00, 32'h40, 1, 0);
        checkOutput("ovf.cause", 32'(exc_cause), 32'd1);
        checkOutput("ovf.pc", exc_pc, 32'h40);
        checkOutput("ovf.flush", 32'(flush), 32'd1);
        applyStimulus("ovf_hold", 1, 4'b0010, 32'h5, 32'h0, 0, 0, 2'b00, 32'h44, 1, 0);
        checkOutput("ovf_hold.flush", 32'(flush), 32'd0);
        checkOutput("ovf_hold.in_ready", 32'(in_ready), 32'd0);
        applyStimulus("ovf_ack", 1, 4'b0010, 32'h5, 32'h0, 0, 0, 2'b00, 32'h44, 1, 1);
        applyStimulus("ovf_after", 1, 4'b0010, 32'h6, 32'h0, 0, 0, 2'b00, 32'h48, 1, 0);
        checkOutput("ovf_after.result", out_result, 32'h6);

        // Divide by zero keeps HI
        applyStimulus("mult3", 1, 4'b1110, 32'h7, 32'h3, 0, 0, 2'b00, 32'h50, 1, 0);
        applyStimulus("div0", 1, 4'b1101, 32'h0, 32'h9, 1, 0, 2'b00, 32'h54, 1, 0);
        checkOutput("div0.cause", 32'(exc_cause), 32'd2);
        checkOutput("div0.hi", hi, 32'h3);
        applyStimulus("div0_ack", 0, 4'b0000, 32'h0, 32'h0, 0, 0, 2'b00, 32'h0, 1, 1);

        // Backpressure
        applyStimulus("bp_fill", 1, 4'b0010, 32'hA1, 32'h0, 0, 0, 2'b00, 32'h60, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("bp_stall", 1, 4'b0010, 32'hB0 + 32'(i), 32'h0, 0, 0, 2'b00, 32'h64, 0, 0);
            checkOutput("bp_stall.result", out_result, 32'hA1);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus("bp_burst", 1, 4'b0011, 32'hC0 + 32'(i), 32'h0, 0, 0, 2'b00, 32'h68, 1, 0);
            checkOutput("bp_burst.result", out_result, 32'hC0 + 32'(i));
        end

        // Reset while an exception is pending
        applyStimulus("pre_rst", 1, 4'b1011, 32'h1, 32'h0, 1, 1, 2'b00, 32'h70, 1, 0);
        rst_n = 1'b0;
        #2;
        modelReset();
        checkAll("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst.in_ready", 32'(in_ready), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [3:0] ops [9];
            ops = '{4'd2, 4'd3, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
            applyStimulus("rand", 1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 8)],
                          ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, $urandom,
                          1'($urandom_range(0, 5) == 0), 1'($urandom), 2'($urandom),
                          $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
